// File: rtl/ex_io_ctrl.sv
// ex_io_ctrl: CPU-mapped board output controller. Each channel can be off, a static level, PWM or blink.
// Define EX_IO_READBACK_EN to build the registered read-back mux on data_o; otherwise data_o is tied to 0.
module ex_io_ctrl #(
    parameter int unsigned           FPGAClkSpeed  = 12000000,
    parameter int unsigned           Channels      = 4,
    parameter int unsigned           address_width = 16,
    parameter int unsigned           data_width    = 8,
    parameter int unsigned           BaseAddress   = 'h9000,
    parameter int unsigned           PwmPrescale   = 47,
    parameter int unsigned           BlinkHz       = 2,
    parameter logic [Channels-1:0]   InvertReset   = '0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] address_i,
    input  logic [data_width-1:0]    data_i,
    input  logic                     we_i,
    output logic [data_width-1:0]    data_o,
    output logic [Channels-1:0]      ex_pin_o
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_LEVEL = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    localparam int unsigned PRESC_W   = (PwmPrescale > 0) ? $clog2(PwmPrescale + 1) : 1;
    localparam int unsigned BLINK_DIV = FPGAClkSpeed / (2 * BlinkHz);
    localparam int unsigned BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRESC_W-1:0]       PRESC_LAST = PRESC_W'(PwmPrescale);
    localparam logic [BLINK_W-1:0]       BLINK_LAST = (BLINK_DIV > 0) ? BLINK_W'(BLINK_DIV - 1) : '0;
    localparam logic [address_width-1:0] BASE       = address_width'(BaseAddress);

    logic [address_width-1:0] offset;
    logic [31:0]              reg_index;
    logic                     sel_invert;
    logic                     sel_level;
    logic [Channels-1:0]      sel_mode;
    logic [Channels-1:0]      sel_duty;

    logic [Channels-1:0]      invert;
    logic [Channels-1:0]      level;
    mode_e                    mode        [Channels];
    logic [7:0]               duty_shadow [Channels];
    logic [7:0]               duty_active [Channels];

    logic [PRESC_W-1:0]       presc;
    logic                     tick;
    logic [7:0]               pwm_cnt;
    logic [BLINK_W-1:0]       blink_cnt;
    logic                     blink_phase;
    logic [Channels-1:0]      mode_value;

    // Addresses below BaseAddress wrap to a huge index and therefore decode as unmapped.
    assign offset    = address_i - BASE;
    assign reg_index = 32'(offset);

    always_comb begin
        sel_invert = (reg_index == 32'd0);
        sel_level  = (reg_index == 32'd1);
        sel_mode   = '0;
        sel_duty   = '0;
        for (int n = 0; n < Channels; n++) begin
            sel_mode[n] = (reg_index == 32'(2 + 2 * n));
            sel_duty[n] = (reg_index == 32'(3 + 2 * n));
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            invert <= InvertReset;
            level  <= '0;
            for (int n = 0; n < Channels; n++) begin
                mode[n]        <= MODE_OFF;
                duty_shadow[n] <= '0;
            end
        end else if (we_i) begin
            if (sel_invert) invert <= data_i[Channels-1:0];
            if (sel_level)  level  <= data_i[Channels-1:0];
            for (int n = 0; n < Channels; n++) begin
                if (sel_mode[n]) mode[n]        <= mode_e'(data_i[1:0]);
                if (sel_duty[n]) duty_shadow[n] <= data_i[7:0];
            end
        end
    end

    assign tick = (presc == PRESC_LAST);

    // duty_active only follows the shadow at the period boundary so a PWM period is never cut short.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            presc   <= '0;
            pwm_cnt <= '0;
            for (int n = 0; n < Channels; n++) begin
                duty_active[n] <= '0;
            end
        end else begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
                if (pwm_cnt == 8'hFF) begin
                    for (int n = 0; n < Channels; n++) begin
                        duty_active[n] <= duty_shadow[n];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    always_comb begin
        mode_value = '0;
        for (int n = 0; n < Channels; n++) begin
            case (mode[n])
                MODE_LEVEL: mode_value[n] = level[n];
                MODE_PWM:   mode_value[n] = (pwm_cnt < duty_active[n]);
                MODE_BLINK: mode_value[n] = blink_phase;
                default:    mode_value[n] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ex_pin_o <= InvertReset;
        end else begin
            ex_pin_o <= mode_value ^ invert;
        end
    end

`ifdef EX_IO_READBACK_EN
    logic [data_width-1:0] rd_value;

    // DUTY reads return the shadow, i.e. the value the CPU last wrote.
    always_comb begin
        rd_value = '0;
        if (sel_invert) rd_value[Channels-1:0] = invert;
        if (sel_level)  rd_value[Channels-1:0] = level;
        for (int n = 0; n < Channels; n++) begin
            if (sel_mode[n]) rd_value[1:0] = mode[n];
            if (sel_duty[n]) rd_value[7:0] = duty_shadow[n];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            data_o <= '0;
        end else begin
            data_o <= rd_value;
        end
    end
`else
    assign data_o = '0;
`endif

endmodule
